// File: rtl/sram_controller_pkg.sv
// Shared types and defaults for the MEM-stage SRAM controller.
package sram_controller_pkg;

    localparam logic [31:0] ADDR_BASE_DEFAULT   = 32'd1024;
    localparam int unsigned SRAM_ADDR_W_DEFAULT = 18;
    localparam int unsigned WAIT_CYCLES_DEFAULT = 2;
    localparam int unsigned WORD_W              = 32;
    localparam int unsigned HALF_W              = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    typedef struct packed {
        logic              is_write;
        logic [WORD_W-1:0] wdata;
    } req_t;

    // Word index relative to the data-memory base; wraps below the base.
    function automatic logic [WORD_W-1:0] word_offset(input logic [WORD_W-1:0] addr,
                                                      input logic [WORD_W-1:0] base);
        return (addr - base) >> 2;
    endfunction

endpackage

// File: rtl/sram_controller.sv
// Splits one 32-bit pipeline load/store into two timed 16-bit async SRAM accesses,
// holding ready low until the word is complete.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEFAULT,
    parameter int unsigned SRAM_ADDR_W = SRAM_ADDR_W_DEFAULT,
    parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [15:0]            sram_dq_out,
    input  logic [15:0]            sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    localparam int unsigned WA_W  = SRAM_ADDR_W - 1;
    localparam int unsigned CNT_W = $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [WA_W-1:0]         wa_q, wa_d;
    req_t                    req_q, req_d;
    logic [WORD_W-1:0]       rdata_q, rdata_d;
    logic [SRAM_ADDR_W-1:0]  addr_q, addr_d;
    logic [HALF_W-1:0]       dq_q, dq_d;
    logic                    oe_q, oe_d;
    logic                    we_n_q, we_n_d;
    logic                    cnt_last;

    assign cnt_last = (cnt_q == CNT_LAST);

    // Next state, half-access counter, request latch and read capture.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wa_d    = wa_q;
        req_d   = req_q;
        rdata_d = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_en || rd_en) begin
                    wa_d           = WA_W'(word_offset(address, ADDR_BASE));
                    req_d.is_write = wr_en;
                    req_d.wdata    = write_data;
                    cnt_d          = '0;
                    state_d        = ST_LOW;
                end
            end
            ST_LOW: begin
                if (cnt_last) begin
                    if (!req_q.is_write) begin
                        rdata_d[15:0] = sram_dq_in;
                    end
                    cnt_d   = '0;
                    state_d = ST_HIGH;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_HIGH: begin
                if (cnt_last) begin
                    if (!req_q.is_write) begin
                        rdata_d[31:16] = sram_dq_in;
                    end
                    cnt_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // SRAM pins are registered from the upcoming state so they line up with it;
    // we_n rises on the last cycle of each half so address and data hold past the strobe.
    always_comb begin
        addr_d = addr_q;
        dq_d   = dq_q;
        oe_d   = 1'b0;
        we_n_d = 1'b1;
        if (state_d == ST_LOW || state_d == ST_HIGH) begin
            addr_d = {wa_d, (state_d == ST_HIGH)};
            if (req_d.is_write) begin
                oe_d   = 1'b1;
                dq_d   = (state_d == ST_HIGH) ? req_d.wdata[31:16] : req_d.wdata[15:0];
                we_n_d = (cnt_d == CNT_LAST);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wa_q    <= '0;
            req_q   <= '0;
            rdata_q <= '0;
            addr_q  <= '0;
            dq_q    <= '0;
            oe_q    <= 1'b0;
            we_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wa_q    <= wa_d;
            req_q   <= req_d;
            rdata_q <= rdata_d;
            addr_q  <= addr_d;
            dq_q    <= dq_d;
            oe_q    <= oe_d;
            we_n_q  <= we_n_d;
        end
    end

    assign ready       = ((state_q == ST_IDLE) && !rd_en && !wr_en) || (state_q == ST_DONE);
    assign read_data   = rdata_q;
    assign sram_addr   = addr_q;
    assign sram_dq_out = dq_q;
    assign sram_dq_oe  = oe_q;
    assign sram_we_n   = we_n_q;

endmodule
